// File: rtl/capture_sequencer_if.sv
// AXI-Stream sample input and DMA packet output bundled for capture_sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface capture_sequencer_if #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 192
);
    logic                              s00_axis_tvalid;
    logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata;
    logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb;
    logic                              s00_axis_tready;
    logic                              m00_axis_tvalid;
    logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata;
    logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb;
    logic                              m00_axis_tlast;
    logic                              m00_axis_tready;

    modport slave (
        input  s00_axis_tvalid,
        input  s00_axis_tdata,
        input  s00_axis_tstrb,
        output s00_axis_tready,
        output m00_axis_tvalid,
        output m00_axis_tdata,
        output m00_axis_tstrb,
        output m00_axis_tlast,
        input  m00_axis_tready
    );

    modport master (
        output s00_axis_tvalid,
        output s00_axis_tdata,
        output s00_axis_tstrb,
        input  s00_axis_tready,
        input  m00_axis_tvalid,
        input  m00_axis_tdata,
        input  m00_axis_tstrb,
        input  m00_axis_tlast,
        output m00_axis_tready
    );
endinterface

// File: rtl/capture_sequencer.sv
// Trigger-driven capture sequencer: gates a sample stream into fixed-length DMA packets,
// with holdoff, re-arm gap, multi-capture runs and packet-aligned abort.
module capture_sequencer #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 192,
    parameter int unsigned PACKET_COUNT       = 512,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic                 s00_axis_aclk,
    input  logic                 s00_axis_aresetn,
    capture_sequencer_if.slave   axis,
    input  logic                 trigger,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] num_captures,
    input  logic [CNT_WIDTH-1:0] holdoff,
    input  logic [CNT_WIDTH-1:0] rearm_delay,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] capture_idx,
    output logic [3:0]           debugger
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StHoldoff = 3'd2,
        StStream  = 3'd3,
        StGap     = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(PACKET_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] One      = CNT_WIDTH'(1);

    state_e               r_state;
    logic                 r_trig_q;
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0] r_capture_idx;
    logic [CNT_WIDTH-1:0] r_num_captures;
    logic [CNT_WIDTH-1:0] r_holdoff;
    logic [CNT_WIDTH-1:0] r_rearm_delay;
    logic [CNT_WIDTH-1:0] r_wait_cnt;
    logic                 r_trig_missed;
    logic                 r_abort_pending;
    logic                 r_done;

    state_e               w_state_next;
    logic [CNT_WIDTH-1:0] w_beat_next;
    logic [CNT_WIDTH-1:0] w_idx_next;
    logic [CNT_WIDTH-1:0] w_num_next;
    logic [CNT_WIDTH-1:0] w_holdoff_next;
    logic [CNT_WIDTH-1:0] w_rearm_next;
    logic [CNT_WIDTH-1:0] w_wait_next;
    logic                 w_missed_next;
    logic                 w_pending_next;
    logic                 w_done_next;

    logic                 w_in_stream;
    logic                 w_trig_edge;
    logic                 w_hs;
    logic                 w_last;
    logic [CNT_WIDTH-1:0] w_new_idx;
    logic                 w_run_done;

    assign w_in_stream = (r_state == StStream);
    assign w_trig_edge = trigger & ~r_trig_q;
    assign w_hs        = w_in_stream & axis.s00_axis_tvalid & axis.m00_axis_tready;
    assign w_last      = w_in_stream & (r_beat_cnt == LastBeat);
    assign w_new_idx   = r_capture_idx + One;
    assign w_run_done  = ((r_num_captures != '0) && (w_new_idx == r_num_captures))
                         | abort | r_abort_pending;

    // Outside STREAM the source is drained so stale samples never reach the DMA.
    assign axis.m00_axis_tvalid = w_in_stream & axis.s00_axis_tvalid;
    assign axis.s00_axis_tready = w_in_stream ? axis.m00_axis_tready : 1'b1;
    assign axis.m00_axis_tlast  = w_last;
    assign axis.m00_axis_tdata  = C_AXIS_TDATA_WIDTH'(axis.s00_axis_tdata);
    assign axis.m00_axis_tstrb  = axis.s00_axis_tstrb;

    assign busy        = (r_state != StIdle);
    assign done        = r_done;
    assign capture_idx = r_capture_idx;
    assign debugger    = {r_trig_missed, r_state};

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_state         <= StIdle;
            r_trig_q        <= 1'b1;
            r_beat_cnt      <= '0;
            r_capture_idx   <= '0;
            r_num_captures  <= '0;
            r_holdoff       <= '0;
            r_rearm_delay   <= '0;
            r_wait_cnt      <= '0;
            r_trig_missed   <= 1'b0;
            r_abort_pending <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_trig_q        <= trigger;
            r_beat_cnt      <= w_beat_next;
            r_capture_idx   <= w_idx_next;
            r_num_captures  <= w_num_next;
            r_holdoff       <= w_holdoff_next;
            r_rearm_delay   <= w_rearm_next;
            r_wait_cnt      <= w_wait_next;
            r_trig_missed   <= w_missed_next;
            r_abort_pending <= w_pending_next;
            r_done          <= w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_beat_next    = r_beat_cnt;
        w_idx_next     = r_capture_idx;
        w_num_next     = r_num_captures;
        w_holdoff_next = r_holdoff;
        w_rearm_next   = r_rearm_delay;
        w_wait_next    = r_wait_cnt;
        w_missed_next  = r_trig_missed;
        w_pending_next = r_abort_pending;
        w_done_next    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (arm) begin
                    w_num_next     = num_captures;
                    w_holdoff_next = holdoff;
                    w_rearm_next   = rearm_delay;
                    w_idx_next     = '0;
                    w_beat_next    = '0;
                    w_missed_next  = 1'b0;
                    w_pending_next = 1'b0;
                    w_state_next   = StArmed;
                end
            end
            StArmed: begin
                if (abort) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end else if (w_trig_edge) begin
                    if (r_holdoff == '0) begin
                        w_state_next = StStream;
                    end else begin
                        w_wait_next  = r_holdoff;
                        w_state_next = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                if (w_trig_edge) w_missed_next = 1'b1;
                if (abort) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end else if (r_wait_cnt <= One) begin
                    w_state_next = StStream;
                end else begin
                    w_wait_next = r_wait_cnt - One;
                end
            end
            StStream: begin
                if (w_trig_edge) w_missed_next = 1'b1;
                if (abort) w_pending_next = 1'b1;
                if (w_hs) begin
                    if (w_last) begin
                        w_beat_next = '0;
                        w_idx_next  = w_new_idx;
                        if (w_run_done) begin
                            w_state_next   = StIdle;
                            w_done_next    = 1'b1;
                            w_pending_next = 1'b0;
                        end else if (r_rearm_delay == '0) begin
                            w_state_next = StArmed;
                        end else begin
                            w_wait_next  = r_rearm_delay;
                            w_state_next = StGap;
                        end
                    end else begin
                        w_beat_next = r_beat_cnt + One;
                    end
                end
            end
            StGap: begin
                if (w_trig_edge) w_missed_next = 1'b1;
                if (abort) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end else if (r_wait_cnt <= One) begin
                    w_state_next = StArmed;
                end else begin
                    w_wait_next = r_wait_cnt - One;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule
